// File: rtl/sdm_pkg.sv
// sdm_pkg: shared constants, state type and saturation helper for the
// second-order sigma-delta modulator.
//   SDM_DATA_W / SDM_OSR / SDM_ACC_W : default widths and oversampling ratio
//   SDM_FS                           : full-scale feedback magnitude
//   sdm_state_e                      : frame FSM states
//   sat_acc()                        : clamp a wide value into an acc_w-bit signed range
package sdm_pkg;

    localparam int SDM_DATA_W = 16;
    localparam int SDM_OSR    = 256;
    localparam int SDM_ACC_W  = 24;
    localparam int SDM_FS     = 1 << (SDM_DATA_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sdm_state_e;

    // Clamp instead of wrapping; a wrapped integrator flips sign and
    // throws the loop into a full-scale limit cycle.
    function automatic logic signed [63:0] sat_acc(input logic signed [63:0] v,
                                                   input int acc_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/sdm_loop2.sv
// sdm_loop2: second-order 1-bit noise-shaping loop (STF = z^-2,
// NTF = (1-z^-1)^2). Two saturating integrators and a sign quantiser.
//   mclk1 : modulator clock (rising edge)
//   reset : asynchronous, active-high
//   en    : advance the loop; when low all state holds
//   x     : signed input word (held for a whole frame by the caller)
//   y     : registered quantiser output, 1 = +FS, 0 = -FS
module sdm_loop2
    import sdm_pkg::*;
#(
    parameter int DATA_W = SDM_DATA_W,
    parameter int ACC_W  = SDM_ACC_W
) (
    input  logic              mclk1,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] x,
    output logic              y
);

    // Two guard bits: |i2| + |i1| + 2*FS always fits without overflow.
    localparam int W2 = ACC_W + 2;
    localparam logic signed [W2-1:0] FS_EXT =
        $signed({{(W2 - DATA_W){1'b0}}, 1'b1, {(DATA_W - 1){1'b0}}});

    logic signed [ACC_W-1:0] i1;
    logic signed [ACC_W-1:0] i2;
    logic signed [ACC_W-1:0] i1_nxt;
    logic signed [ACC_W-1:0] i2_nxt;
    logic signed [W2-1:0]    fb;
    logic signed [W2-1:0]    s1;
    logic signed [W2-1:0]    s2;
    logic                    q;

    assign q = ~i2[ACC_W-1];    // i2 >= 0

    always_comb begin
        fb = q ? FS_EXT : -FS_EXT;
        s1 = $signed({{2{i1[ACC_W-1]}}, i1})
           + $signed({{(W2 - DATA_W){x[DATA_W-1]}}, x})
           - fb;
        s2 = $signed({{2{i2[ACC_W-1]}}, i2})
           + $signed({{2{i1[ACC_W-1]}}, i1})
           - (fb <<< 1);
        i1_nxt = ACC_W'(sat_acc(64'(s1), ACC_W));
        i2_nxt = ACC_W'(sat_acc(64'(s2), ACC_W));
    end

    always_ff @(posedge mclk1 or posedge reset) begin
        if (reset) begin
            i1 <= '0;
            i2 <= '0;
            y  <= 1'b0;
        end else if (en) begin
            i1 <= i1_nxt;
            i2 <= i2_nxt;
            y  <= q;
        end
    end

endmodule

// File: rtl/sigma_delta_modulator.sv
// sigma_delta_modulator: second-order 1-bit sigma-delta modulator with a
// valid/ready PCM input, one-entry word buffer and zero-order-hold over OSR
// modulator clocks.
//   mclk1       : modulator clock, all logic on rising edge
//   reset       : asynchronous, active-high
//   en          : modulator enable; when low the loop, frame counter and
//                 current word freeze (the buffer can still be filled)
//   s_data      : signed PCM sample
//   s_valid     : sample valid
//   s_ready     : block can accept a sample (= buffer empty)
//   mdata       : bitstream, 1 = +FS, 0 = -FS
//   word_strobe : one-cycle pulse when a new word becomes the loop input
//   underrun    : one-cycle pulse when a frame ends with nothing to load
module sigma_delta_modulator
    import sdm_pkg::*;
#(
    parameter int DATA_W = SDM_DATA_W,
    parameter int OSR    = SDM_OSR,
    parameter int ACC_W  = SDM_ACC_W
) (
    input  logic              mclk1,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mdata,
    output logic              word_strobe,
    output logic              underrun
);

    localparam int CNT_W = $clog2(OSR);

    sdm_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] cur, cur_nxt;
    logic [DATA_W-1:0] buf_data, buf_nxt;
    logic              buf_full, full_nxt;
    logic              ws_nxt, ur_nxt;
    logic              accept;
    logic              frame_end;

    assign s_ready   = ~buf_full;
    assign accept    = s_valid & ~buf_full;
    assign frame_end = (state == RUN) && (cnt == CNT_W'(OSR - 1));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cur_nxt   = cur;
        buf_nxt   = buf_data;
        full_nxt  = buf_full;
        ws_nxt    = 1'b0;
        ur_nxt    = 1'b0;
        if (!en) begin
            if (accept) begin
                buf_nxt  = s_data;
                full_nxt = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    // A word parked while disabled starts the stream first.
                    if (buf_full) begin
                        cur_nxt   = buf_data;
                        full_nxt  = 1'b0;
                        ws_nxt    = 1'b1;
                        state_nxt = RUN;
                    end else if (accept) begin
                        cur_nxt   = s_data;
                        ws_nxt    = 1'b1;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    cnt_nxt = cnt + CNT_W'(1);    // OSR is a power of two: wraps
                    if (frame_end) begin
                        if (buf_full) begin
                            cur_nxt  = buf_data;
                            full_nxt = 1'b0;
                            ws_nxt   = 1'b1;
                        end else if (s_valid) begin
                            // Empty buffer: bypass straight into the loop.
                            cur_nxt = s_data;
                            ws_nxt  = 1'b1;
                        end else begin
                            ur_nxt = 1'b1;
                        end
                    end else if (accept) begin
                        buf_nxt  = s_data;
                        full_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge mclk1 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            cur         <= '0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            word_strobe <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cur         <= cur_nxt;
            buf_data    <= buf_nxt;
            buf_full    <= full_nxt;
            word_strobe <= ws_nxt;
            underrun    <= ur_nxt;
        end
    end

    sdm_loop2 #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_loop (
        .mclk1 (mclk1),
        .reset (reset),
        .en    (en),
        .x     (cur),
        .y     (mdata)
    );

endmodule
